// File: rtl/i2c_pkg.sv
// Shared constants and state encoding for the I2C target register front end.
package i2c_pkg;

    localparam int   I2C_BYTE_W = 8;
    localparam logic ACK        = 1'b0;
    localparam logic NACK       = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_MACK,
        ST_IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C pad line: 2-flop synchroniser, optional stability filter and edge
// detection. Build option: I2C_INPUT_FILTER_EN adds a FILTER_LEN-cycle filter.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int SYNC_STAGES = 2;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_level;
    logic                   filt_level;
    logic                   prev_reg;

    // Resample the asynchronous pad; reset to the idle (released) bus level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_i};
        end
    end

    assign sync_level = sync_reg[SYNC_STAGES-1];

`ifdef I2C_INPUT_FILTER_EN
    localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             filt_reg;

    // Accept a new level only after it has been seen on FILTER_LEN consecutive clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_reg <= 1'b1;
            cnt_reg  <= '0;
        end else if (sync_level == filt_reg) begin
            cnt_reg  <= '0;
        end else if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
            filt_reg <= sync_level;
            cnt_reg  <= '0;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

    assign filt_level = filt_reg;
`else
    // Unfiltered build: the synchroniser output is used directly.
    logic unused_filter_len;
    assign unused_filter_len = (FILTER_LEN != 0);
    assign filt_level        = sync_level;
`endif

    // Remember the previous clean level so edges are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= filt_level;
        end
    end

    assign level_o = filt_level;
    assign rise_o  = filt_level & ~prev_reg;
    assign fall_o  = ~filt_level & prev_reg;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target front end for the LED controller register map: START/STOP decode,
// device address match, register pointer, auto-incrementing burst read/write.
// Build option: I2C_INPUT_FILTER_EN enables the per-line glitch filter.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS    = 7'h69,
    parameter int         ADDR_W     = 4,
    parameter int         FILTER_LEN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        wr_data,
    output logic              wr_en,
    output logic              rd_req,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              start_o,
    output logic              stop_o
);

    localparam int         LINE_SCL  = 0;
    localparam int         LINE_SDA  = 1;
    localparam logic [3:0] LAST_BIT  = 4'(I2C_BYTE_W - 1);
    localparam logic [3:0] BYTE_BITS = 4'(I2C_BYTE_W);

    logic [1:0] pad_in;
    logic [1:0] line_level;
    logic [1:0] line_rise;
    logic [1:0] line_fall;

    assign pad_in[LINE_SCL] = scl_i;
    assign pad_in[LINE_SDA] = sda_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            i2c_line_filter #(
                .FILTER_LEN (FILTER_LEN)
            ) u_line (
                .clk     (clk),
                .reset   (reset),
                .line_i  (pad_in[gi]),
                .level_o (line_level[gi]),
                .rise_o  (line_rise[gi]),
                .fall_o  (line_fall[gi])
            );
        end
    endgenerate

    logic scl_level, scl_rise, scl_fall, sda_level;
    logic start_det, stop_det;

    assign scl_level = line_level[LINE_SCL];
    assign scl_rise  = line_rise[LINE_SCL];
    assign scl_fall  = line_fall[LINE_SCL];
    assign sda_level = line_level[LINE_SDA];
    assign start_det = line_fall[LINE_SDA] & scl_level;
    assign stop_det  = line_rise[LINE_SDA] & scl_level;

    i2c_state_e              state_reg, state_next;
    logic [3:0]              bit_cnt_reg, bit_cnt_next;
    logic [I2C_BYTE_W-1:0]   shift_reg, shift_next;
    logic [I2C_BYTE_W-1:0]   byte_in;
    logic                    sda_oe_reg, sda_oe_next;
    logic                    busy_reg, busy_next;
    logic                    rw_reg, rw_next;
    logic                    acked_reg, acked_next;
    logic [ADDR_W-1:0]       reg_addr_reg, reg_addr_next;
    logic [7:0]              wr_data_reg, wr_data_next;
    logic                    wr_en_reg, wr_en_next;
    logic                    rd_req_reg, rd_req_next;
    logic                    rd_dly_reg, rd_dly_next;
    logic                    start_reg, start_next;
    logic                    stop_reg, stop_next;

    // Byte as it stands once the bit on the current SCL rise is included.
    assign byte_in = {shift_reg[I2C_BYTE_W-2:0], sda_level};

    // Register all protocol state; reset releases SDA and clears the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            sda_oe_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            rw_reg       <= 1'b0;
            acked_reg    <= 1'b0;
            reg_addr_reg <= '0;
            wr_data_reg  <= '0;
            wr_en_reg    <= 1'b0;
            rd_req_reg   <= 1'b0;
            rd_dly_reg   <= 1'b0;
            start_reg    <= 1'b0;
            stop_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            sda_oe_reg   <= sda_oe_next;
            busy_reg     <= busy_next;
            rw_reg       <= rw_next;
            acked_reg    <= acked_next;
            reg_addr_reg <= reg_addr_next;
            wr_data_reg  <= wr_data_next;
            wr_en_reg    <= wr_en_next;
            rd_req_reg   <= rd_req_next;
            rd_dly_reg   <= rd_dly_next;
            start_reg    <= start_next;
            stop_reg     <= stop_next;
        end
    end

    // Next-state logic: START/STOP override everything, then per-state bit handling.
    // ACK phases use acked_reg: first SCL fall drives the ACK, second one releases it.
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        sda_oe_next   = sda_oe_reg;
        busy_next     = busy_reg;
        rw_next       = rw_reg;
        acked_next    = acked_reg;
        reg_addr_next = reg_addr_reg;
        wr_data_next  = wr_data_reg;
        wr_en_next    = 1'b0;
        rd_req_next   = 1'b0;
        rd_dly_next   = rd_req_reg;
        start_next    = 1'b0;
        stop_next     = 1'b0;

        if (start_det) begin
            state_next   = ST_DEV_ADDR;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b0;
            acked_next   = 1'b0;
            start_next   = 1'b1;
        end else if (stop_det) begin
            state_next   = ST_IDLE;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b0;
            acked_next   = 1'b0;
            busy_next    = 1'b0;
            stop_next    = 1'b1;
        end else begin
            case (state_reg)
                ST_DEV_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_next = byte_in;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_next = '0;
                            if (state_reg == ST_DEV_ADDR) begin
                                if (shift_reg[6:0] == ADDRESS) begin
                                    state_next = ST_DEV_ACK;
                                    rw_next    = sda_level;
                                    busy_next  = 1'b1;
                                end else begin
                                    state_next = ST_IGNORE;
                                end
                            end else if (state_reg == ST_PTR) begin
                                reg_addr_next = byte_in[ADDR_W-1:0];
                                state_next    = ST_PTR_ACK;
                            end else begin
                                wr_data_next = byte_in;
                                wr_en_next   = 1'b1;
                                state_next   = ST_WR_ACK;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end
                end

                ST_DEV_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!acked_reg) begin
                            sda_oe_next = ~ACK;
                            acked_next  = 1'b1;
                        end else begin
                            sda_oe_next = 1'b0;
                            acked_next  = 1'b0;
                            if (state_reg == ST_DEV_ACK) begin
                                if (rw_reg) begin
                                    state_next  = ST_RD_DATA;
                                    rd_req_next = 1'b1;
                                end else begin
                                    state_next  = ST_PTR;
                                end
                            end else begin
                                state_next = ST_WR_DATA;
                                if (state_reg == ST_WR_ACK) begin
                                    reg_addr_next = reg_addr_reg + 1'b1;
                                end
                            end
                        end
                    end
                end

                ST_RD_DATA: begin
                    if (rd_dly_reg) begin
                        shift_next  = {rd_data[6:0], 1'b0};
                        sda_oe_next = ~rd_data[7];
                    end
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                    if (scl_fall) begin
                        if (bit_cnt_reg == BYTE_BITS) begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = '0;
                            state_next   = ST_RD_MACK;
                        end else begin
                            sda_oe_next = ~shift_reg[7];
                            shift_next  = {shift_reg[6:0], 1'b0};
                        end
                    end
                end

                ST_RD_MACK: begin
                    if (scl_rise) begin
                        if (sda_level == NACK) begin
                            state_next = ST_IGNORE;
                        end else begin
                            reg_addr_next = reg_addr_reg + 1'b1;
                            acked_next    = 1'b1;
                        end
                    end
                    if (scl_fall && acked_reg) begin
                        acked_next   = 1'b0;
                        rd_req_next  = 1'b1;
                        bit_cnt_next = '0;
                        state_next   = ST_RD_DATA;
                    end
                end

                default: begin
                    // IDLE and IGNORE only react to START/STOP
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_reg;
    assign reg_addr = reg_addr_reg;
    assign wr_data  = wr_data_reg;
    assign wr_en    = wr_en_reg;
    assign rd_req   = rd_req_reg;
    assign busy     = busy_reg;
    assign start_o  = start_reg;
    assign stop_o   = stop_reg;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller, scoreboard queues for
// expected register writes and read requests, and per-byte ACK/data checks.
module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam int ADDR_W = 4;
    localparam int Q      = 10;   // clk cycles per quarter SCL period

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              scl_drv = 1'b1;
    logic              sda_drv = 1'b1;
    logic              sda_bus;
    logic              sda_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              rd_req;
    logic [7:0]        rd_data;
    logic              busy;
    logic              start_o;
    logic              stop_o;

    int n_checks = 0;
    int n_fail   = 0;
    int oe_cnt    = 0;
    int start_cnt = 0;
    int stop_cnt  = 0;

    logic [ADDR_W+7:0] exp_wr_q[$];
    logic [ADDR_W-1:0] exp_rd_q[$];

    always #5 clk = ~clk;

    // Open-drain bus: either side can pull SDA low.
    assign sda_bus = sda_drv & ~sda_oe;
    // Register file model: byte at address a reads as 0x10 + a.
    assign rd_data = 8'h10 + 8'(reg_addr);

    i2c_target_regs #(
        .ADDRESS    (7'h69),
        .ADDR_W     (ADDR_W),
        .FILTER_LEN (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (scl_drv),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .busy     (busy),
        .start_o  (start_o),
        .stop_o   (stop_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write/read request.
    always @(negedge clk) begin
        if (!reset) begin
            if (sda_oe)  oe_cnt++;
            if (start_o) start_cnt++;
            if (stop_o)  stop_cnt++;
            if (wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 32'(wr_en), 32'd0);
                end else begin
                    logic [ADDR_W+7:0] e;
                    e = exp_wr_q.pop_front();
                    $display("wr  addr=%0h data=%02h", reg_addr, wr_data);
                    check("wr_addr", 32'(reg_addr), 32'(e[ADDR_W+7:8]));
                    check("wr_data", 32'(wr_data), 32'(e[7:0]));
                end
            end
            if (rd_req) begin
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected", 32'(rd_req), 32'd0);
                end else begin
                    logic [ADDR_W-1:0] a;
                    a = exp_rd_q.pop_front();
                    $display("rd  addr=%0h", reg_addr);
                    check("rd_addr", 32'(reg_addr), 32'(a));
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period: data set mid-low, sampled mid-high; optional 1-clk SCL dip.
    task automatic bus_bit(input logic b, input logic glitch, output logic smp);
        sda_drv = b;
        wait_clk(Q);
        scl_drv = 1'b1;
        wait_clk(Q / 2);
        if (glitch) begin
            scl_drv = 1'b0;
            wait_clk(1);
            scl_drv = 1'b1;
            wait_clk(Q / 2 - 1);
        end else begin
            wait_clk(Q / 2);
        end
        smp = sda_bus;
        wait_clk(Q);
        scl_drv = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1;
        wait_clk(Q);
        scl_drv = 1'b1;
        wait_clk(Q);
        sda_drv = 1'b0;
        wait_clk(Q);
        scl_drv = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0;
        wait_clk(Q);
        scl_drv = 1'b1;
        wait_clk(Q);
        sda_drv = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string tag,
                              input int glitch_bit = -1);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], (i == glitch_bit), s);
        bus_bit(1'b1, 1'b0, s);
        $display("byte %02h ack=%0b (%s)", d, s, tag);
        check(tag, 32'(s), 32'(exp_ack));
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] exp, input string tag);
        logic [7:0] v;
        logic       s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, s);
            v[i] = s;
        end
        bus_bit(mack, 1'b0, s);
        $display("read %02h mack=%0b (%s)", v, mack, tag);
        check(tag, 32'(v), 32'(exp));
    endtask

    initial begin
        int         s0, p0, o0;
        logic [7:0] d1, d2;
        logic       s;

        // Reset state
        wait_clk(5);
        check("rst_sda_oe",   32'(sda_oe),   32'd0);
        check("rst_wr_en",    32'(wr_en),    32'd0);
        check("rst_rd_req",   32'(rd_req),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_start_o",  32'(start_o),  32'd0);
        check("rst_stop_o",   32'(stop_o),   32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_wr_data",  32'(wr_data),  32'd0);
        reset = 1'b0;
        wait_clk(5);

        // Write burst to pointer 5
        s0 = start_cnt; p0 = stop_cnt;
        exp_wr_q.push_back({ADDR_W'(5), 8'hA5});
        exp_wr_q.push_back({ADDR_W'(6), 8'h3C});
        bus_start();
        write_byte(8'hD2, ACK, "wb_dev_ack");
        check("wb_busy", 32'(busy), 32'd1);
        write_byte(8'h05, ACK, "wb_ptr_ack");
        write_byte(8'hA5, ACK, "wb_d0_ack");
        write_byte(8'h3C, ACK, "wb_d1_ack");
        bus_stop();
        check("wb_start_cnt", 32'(start_cnt - s0), 32'd1);
        check("wb_stop_cnt",  32'(stop_cnt - p0),  32'd1);
        check("wb_busy_after", 32'(busy), 32'd0);
        check("wb_reg_addr", 32'(reg_addr), 32'd7);
        check("wb_wr_left", 32'(exp_wr_q.size()), 32'd0);

        // Pointer set, repeated START, two-byte read
        s0 = start_cnt;
        exp_rd_q.push_back(ADDR_W'(5));
        exp_rd_q.push_back(ADDR_W'(6));
        bus_start();
        write_byte(8'hD2, ACK, "rd_wdev_ack");
        write_byte(8'h05, ACK, "rd_ptr_ack");
        bus_start();
        write_byte(8'hD3, ACK, "rd_rdev_ack");
        read_byte(ACK,  8'h10 + 8'd5, "rd_byte0");
        read_byte(NACK, 8'h10 + 8'd6, "rd_byte1");
        bus_stop();
        check("rd_start_cnt", 32'(start_cnt - s0), 32'd2);
        check("rd_left", 32'(exp_rd_q.size()), 32'd0);
        check("rd_busy_after", 32'(busy), 32'd0);
        check("rd_sda_oe_after", 32'(sda_oe), 32'd0);

        // Address mismatch: no ACK, no activity
        o0 = oe_cnt;
        bus_start();
        write_byte(8'hA0, NACK, "mm_dev_nack");
        check("mm_busy", 32'(busy), 32'd0);
        write_byte(8'h55, NACK, "mm_data_nack");
        bus_stop();
        check("mm_oe_cnt", 32'(oe_cnt - o0), 32'd0);

        // Pointer wrap: 0x1F keeps low bits, writes land at 0xF then 0x0
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        exp_wr_q.push_back({ADDR_W'(15), d1});
        exp_wr_q.push_back({ADDR_W'(0),  d2});
        bus_start();
        write_byte(8'hD2, ACK, "wr_dev_ack");
        write_byte(8'h1F, ACK, "wr_ptr_ack");
        write_byte(d1, ACK, "wr_d0_ack");
        write_byte(d2, ACK, "wr_d1_ack");
        bus_stop();
        check("wrap_wr_left", 32'(exp_wr_q.size()), 32'd0);
        check("wrap_reg_addr", 32'(reg_addr), 32'd1);

        // Abort mid data byte, then a clean transaction
        bus_start();
        write_byte(8'hD2, ACK, "ab_dev_ack");
        write_byte(8'h02, ACK, "ab_ptr_ack");
        for (int i = 0; i < 4; i++) bus_bit(1'b1, 1'b0, s);
        bus_stop();
        check("ab_sda_oe", 32'(sda_oe), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_reg_addr", 32'(reg_addr), 32'd2);
        exp_wr_q.push_back({ADDR_W'(3), 8'h77});
        bus_start();
        write_byte(8'hD2, ACK, "ab2_dev_ack");
        write_byte(8'h03, ACK, "ab2_ptr_ack");
        write_byte(8'h77, ACK, "ab2_d0_ack");
        bus_stop();
        check("ab2_wr_left", 32'(exp_wr_q.size()), 32'd0);

`ifdef I2C_INPUT_FILTER_EN
        // SCL glitch mid-bit must not add a bit
        exp_wr_q.push_back({ADDR_W'(8), 8'h5A});
        bus_start();
        write_byte(8'hD2, ACK, "gl_dev_ack");
        write_byte(8'h08, ACK, "gl_ptr_ack");
        write_byte(8'h5A, ACK, "gl_d0_ack", 3);
        bus_stop();
        check("gl_wr_left", 32'(exp_wr_q.size()), 32'd0);
`endif

        // Reset while the target drives the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a;
            a = 8'hD2;
            bus_bit(a[i], 1'b0, s);
        end
        check("mr_ack_drive", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        wait_clk(1);
        check("mr_sda_release", 32'(sda_oe), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        sda_drv = 1'b1;
        scl_drv = 1'b1;
        wait_clk(Q);
        reset = 1'b0;
        wait_clk(Q);

        check("end_wr_left", 32'(exp_wr_q.size()), 32'd0);
        check("end_rd_left", 32'(exp_rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
Parametrised I2C target (slave) front end for the LED controller register map. It decodes START, repeated START and STOP. It ACKs its 7-bit device address and loads a register pointer from the first data byte. It then performs multi-byte writes and multi-byte reads with pointer auto-increment. It sits between the chip pads (open-drain via output enable) and the register file / LED datapath.

Parameters:
ADDRESS, 7'h69, 7-bit device address matched after START
ADDR_W, 4, register pointer width; register space is 2^ADDR_W bytes
FILTER_LEN, 3, input glitch-filter length in clk cycles (used only with I2C_INPUT_FILTER_EN)

Ports:
clk  in  1  system clock, at least 8x SCL rate
reset  in  1  synchronous, active-high
scl_i  in  1  SCL pad input
sda_i  in  1  SDA pad input
sda_oe  out  1  1 = pull SDA low (open-drain)
reg_addr  out  ADDR_W  current register pointer
wr_data  out  8  byte written by controller
wr_en  out  1  one-cycle pulse; wr_data is valid for reg_addr
rd_req  out  1  one-cycle pulse; requests the byte at reg_addr
rd_data  in  8  read byte; must be valid by the 2nd clk after rd_req
busy  out  1  high from addressed START until STOP
start_o  out  1  one-cycle pulse on START or repeated START
stop_o  out  1  one-cycle pulse on STOP

Behaviour:
- Reset: sda_oe=0, wr_en=0, rd_req=0, busy=0, start_o=0, stop_o=0, reg_addr=0, wr_data=0, state=IDLE.
- Inputs pass a 2-flop synchroniser. Edge detection and START/STOP detection use only synchronised values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both take priority over any state.
- Bits are sampled on SCL rise, MSB first. sda_oe changes only on SCL fall, START or STOP.
- States: IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK, IGNORE.
- IDLE: waits for START.
- START from any state: go to DEV_ADDR, bit counter=0, sda_oe=0, pulse start_o. reg_addr is retained, so a repeated START reads from the pointer just set.
- DEV_ADDR: shift 8 bits.
  - Address match, R/W=0: go to DEV_ACK, then PTR.
  - Address match, R/W=1: go to DEV_ACK, then RD_DATA.
  - Mismatch: go to IGNORE with no ACK; sda_oe stays 0 until the next START.
- ACK timing: sda_oe=1 from the SCL fall after the 8th bit until the next SCL fall.
- PTR: 8 bits; reg_addr = low ADDR_W bits, upper bits ignored. Then PTR_ACK, then WR_DATA.
- WR_DATA: 8 bits.
  - wr_data and wr_en pulse 1 clk after the 8th SCL rise, using the current reg_addr.
  - reg_addr increments on the ACK SCL fall and wraps modulo 2^ADDR_W.
  - Then WR_ACK, then WR_DATA.
- RD_DATA:
  - rd_req pulses on the SCL fall that ends DEV_ACK or RD_MACK.
  - rd_data is latched 2 clk later into the shift register.
  - sda_oe = ~bit, with the MSB driven at latch time and later bits on each SCL fall.
  - After 8 bits, release SDA and go to RD_MACK.
- RD_MACK: sample SDA on SCL rise.
  - SDA=0 (controller ACK): increment and wrap reg_addr, then go to RD_DATA.
  - SDA=1 (NACK): go to IGNORE.
- STOP anywhere: sda_oe=0 within 1 clk, busy=0, pulse stop_o, go to IDLE.
- A STOP or START mid-byte discards the partial byte; no wr_en is issued.
- busy=1 from a matched DEV_ACK until STOP.
- START and STOP in the same clk cannot occur, since each requires its own SDA edge.
- Reset mid-transfer releases SDA immediately.

Optional Feature:
- I2C_INPUT_FILTER_EN defined:
  - Each synchronised input feeds a FILTER_LEN-cycle stability filter.
  - The filtered value changes only after the input holds a new level for FILTER_LEN consecutive clks.
  - Glitches shorter than that are suppressed, and latency grows by FILTER_LEN clk.
- Undefined: no filter; only the 2-flop synchroniser is present.

Decomposition:
- Package i2c_pkg: state encoding constants, I2C_BYTE_W=8, ACK=1'b0 / NACK=1'b1 constants.
- One sub-module, i2c_line_filter: synchroniser, optional filter and edge detect. It is instantiated once for SCL and once for SDA.
- The FSM, shift register and pointer stay in i2c_target_regs.

Test Plan:
- Write burst: START, 0xD2, 0x05, 0xA5, 0x3C, STOP -> four ACKs; wr_en at reg_addr 5 with 0xA5, then at 6 with 0x3C; stop_o pulse; busy=0 after.
- Pointer-set plus read: START, 0xD2, 0x05, Sr, 0xD3; controller ACKs one byte, NACKs the second, STOP; rd_data = 8'h10+reg_addr -> rd_req at addresses 5 and 6; SDA carries 0x15 then 0x16.
- Address mismatch: START, 0xA0 -> sda_oe never asserts; no wr_en/rd_req; busy=0.
- Wrap, ADDR_W=4: pointer 0x1F then two data bytes -> wr_en at reg_addr 0xF then 0x0.
- Abort: STOP after 4 bits of a data byte -> no wr_en; sda_oe=0; next transaction starts cleanly.
- Glitch (with I2C_INPUT_FILTER_EN, FILTER_LEN=3): 1-clk SCL low pulse mid-bit -> no extra bit shifted; byte still ACKed correctly.
